// File: rtl/cut_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cut_mon_pkg
// Description : Shared types and helpers for the CUT response monitor:
//               burst-tracker state encoding, event record layout at the
//               default widths, and a saturating increment.
// Revision    : 1.0 - initial release
// ============================================================================
package cut_mon_pkg;

  localparam int OUT_W_DEF = 2;
  localparam int TS_W_DEF  = 16;
  localparam int LEN_W_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Event record as it appears on the output stream (MSB first).
  typedef struct packed {
    logic [TS_W_DEF-1:0]  start_ts;
    logic [LEN_W_DEF-1:0] len;
    logic [OUT_W_DEF-1:0] mask;
  } evt_rec_t;

  // Increment that sticks at max_val; callers zero-extend to 32 bits and
  // truncate the result back to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_val);
    return (value >= max_val) ? value : value + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cut_mon_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cut_mon_fifo
// Description : Synchronous FIFO for event records. Head entry is presented
//               straight from the storage registers (first-word fall-through)
//               and forced to zero while empty. A push into a full FIFO is
//               accepted only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cut_mon_fifo #(
  parameter int DATA_W = 26,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              push_accepted,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              full,
  output logic              empty
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              w_pop;

  assign empty         = (count_q == '0);
  assign full          = (count_q == FULL_CNT);
  assign w_pop         = !empty && out_ready;
  assign push_accepted = in_valid && (!full || w_pop);
  assign out_data      = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer, occupancy and storage updates for this cycle's push/pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_accepted) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_accepted, w_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cut_response_monitor.sv
`default_nettype none
// ============================================================================
// Module      : cut_response_monitor
// Description : Compares observed CUT outputs against golden outputs on every
//               valid enabled sample, groups mismatches into bursts closed by
//               GAP_LIMIT clean samples (or by enable dropping), and streams
//               one {start_ts, len, mask} record per burst through a FIFO.
//               Optional macro CUT_MON_PER_BIT_EN adds per-output-bit
//               saturating mismatch counters on port bit_err_count.
// Revision    : 1.0 - initial release
// ============================================================================
module cut_response_monitor
  import cut_mon_pkg::*;
#(
  parameter int OUT_W      = 2,
  parameter int TS_W       = 16,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 16,
  parameter int GAP_LIMIT  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sample_valid,
  input  logic [OUT_W-1:0] obs,
  input  logic [OUT_W-1:0] gold,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [TS_W-1:0]  evt_start_ts,
  output logic [LEN_W-1:0] evt_len,
  output logic [OUT_W-1:0] evt_mask,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] burst_count,
  output logic             overflow,
  output logic             busy
`ifdef CUT_MON_PER_BIT_EN
 ,output logic [OUT_W*CNT_W-1:0] bit_err_count
`endif
);

  // Widths up to 32 bits are supported for LEN_W and CNT_W.
  localparam int          REC_W   = TS_W + LEN_W + OUT_W;
  localparam logic [31:0] LEN_MAX = 32'({LEN_W{1'b1}});
  localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

  state_e           state_q, state_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [TS_W-1:0]  start_ts_q, start_ts_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [OUT_W-1:0] mask_q, mask_d;
  logic [7:0]       gap_q, gap_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] burst_count_q, burst_count_d;
  logic             overflow_q, overflow_d;

  logic [OUT_W-1:0] w_diff;
  logic             w_take;
  logic             w_mis;
  logic             w_clean;
  logic             w_close;
  logic [31:0]      w_len_sum;
  logic [31:0]      w_len_sat;
  logic [31:0]      w_gap_inc;
  logic             w_push_accepted;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [REC_W-1:0] w_evt_data;

  assign w_diff    = obs ^ gold;
  assign w_take    = sample_valid && enable;
  assign w_mis     = w_take && (w_diff != '0);
  assign w_clean   = w_take && (w_diff == '0);
  // gap_q is zero while in BURST, so one sum serves both extend cases.
  assign w_len_sum = 32'(len_q) + 32'(gap_q) + 32'd1;
  assign w_len_sat = (w_len_sum > LEN_MAX) ? LEN_MAX : w_len_sum;
  assign w_gap_inc = 32'(gap_q) + 32'd1;

  // Burst tracker: open on a mismatch, extend across short clean gaps, close
  // after GAP_LIMIT clean samples or when the monitor is disabled.
  always_comb begin
    state_d    = state_q;
    start_ts_d = start_ts_q;
    len_d      = len_q;
    mask_d     = mask_q;
    gap_d      = gap_q;
    w_close    = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_mis) begin
          start_ts_d = ts_q;
          len_d      = LEN_W'(1);
          mask_d     = w_diff;
          gap_d      = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (!enable) begin
          w_close = 1'b1;
        end else if (w_mis) begin
          len_d  = LEN_W'(w_len_sat);
          mask_d = mask_q | w_diff;
        end else if (w_clean) begin
          gap_d = 8'd1;
          if (GAP_LIMIT == 1) begin
            w_close = 1'b1;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (!enable) begin
          w_close = 1'b1;
        end else if (w_mis) begin
          len_d   = LEN_W'(w_len_sat);
          mask_d  = mask_q | w_diff;
          gap_d   = '0;
          state_d = BURST;
        end else if (w_clean) begin
          gap_d = gap_q + 8'd1;
          if (w_gap_inc == 32'(GAP_LIMIT)) begin
            w_close = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (w_close) begin
      state_d = IDLE;
      gap_d   = '0;
    end
  end

  // Timestamp, mismatch/burst statistics and the sticky drop flag.
  always_comb begin
    ts_d          = w_take ? ts_q + TS_W'(1) : ts_q;
    err_count_d   = err_count_q;
    burst_count_d = burst_count_q;
    overflow_d    = overflow_q;
    if (w_mis) begin
      err_count_d = CNT_W'(sat_inc(32'(err_count_q), CNT_MAX));
    end
    if (w_close) begin
      burst_count_d = CNT_W'(sat_inc(32'(burst_count_q), CNT_MAX));
      if (w_fifo_full && !w_push_accepted) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Monitor state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ts_q          <= '0;
      start_ts_q    <= '0;
      len_q         <= '0;
      mask_q        <= '0;
      gap_q         <= '0;
      err_count_q   <= '0;
      burst_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ts_q          <= ts_d;
      start_ts_q    <= start_ts_d;
      len_q         <= len_d;
      mask_q        <= mask_d;
      gap_q         <= gap_d;
      err_count_q   <= err_count_d;
      burst_count_q <= burst_count_d;
      overflow_q    <= overflow_d;
    end
  end

  cut_mon_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (w_close),
    .in_data       ({start_ts_q, len_q, mask_q}),
    .push_accepted (w_push_accepted),
    .out_ready     (evt_ready),
    .out_data      (w_evt_data),
    .full          (w_fifo_full),
    .empty         (w_fifo_empty)
  );

  assign evt_valid                           = !w_fifo_empty;
  assign {evt_start_ts, evt_len, evt_mask}   = w_evt_data;
  assign err_count                           = err_count_q;
  assign burst_count                         = burst_count_q;
  assign overflow                            = overflow_q;
  assign busy                                = (state_q != IDLE);

`ifdef CUT_MON_PER_BIT_EN
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_per_bit
      logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

      // Count mismatches of this output bit on valid enabled samples.
      always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (w_take && w_diff[gi]) begin
          bit_cnt_d = CNT_W'(sat_inc(32'(bit_cnt_q), CNT_MAX));
        end
      end

      // Per-bit counter register.
      always_ff @(posedge clk) begin
        if (rst) begin
          bit_cnt_q <= '0;
        end else begin
          bit_cnt_q <= bit_cnt_d;
        end
      end

      assign bit_err_count[gi*CNT_W +: CNT_W] = bit_cnt_q;
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_cut_response_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cut_response_monitor
// Description : Self-checking bench for cut_response_monitor. A sample-index
//               based burst model and a record queue predict every output
//               each cycle; directed sequences pin literal expectations, then
//               randomized traffic with backpressure, enable drops and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cut_response_monitor;

  localparam int OUT_W     = 2;
  localparam int TS_W      = 16;
  localparam int LEN_W     = 8;
  localparam int CNT_W     = 16;
  localparam int GAP_LIMIT = 4;
  localparam int DEPTH     = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             sample_valid = 1'b0;
  logic [OUT_W-1:0] obs = '0;
  logic [OUT_W-1:0] gold = '0;
  logic             evt_ready = 1'b0;
  logic             evt_valid;
  logic [TS_W-1:0]  evt_start_ts;
  logic [LEN_W-1:0] evt_len;
  logic [OUT_W-1:0] evt_mask;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] burst_count;
  logic             overflow;
  logic             busy;
`ifdef CUT_MON_PER_BIT_EN
  logic [OUT_W*CNT_W-1:0] bit_err_count;
`endif

  cut_response_monitor #(
    .OUT_W(OUT_W), .TS_W(TS_W), .LEN_W(LEN_W), .CNT_W(CNT_W),
    .GAP_LIMIT(GAP_LIMIT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .obs(obs), .gold(gold), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_start_ts(evt_start_ts), .evt_len(evt_len), .evt_mask(evt_mask),
    .err_count(err_count), .burst_count(burst_count),
    .overflow(overflow), .busy(busy)
`ifdef CUT_MON_PER_BIT_EN
   ,.bit_err_count(bit_err_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input longint unsigned act,
                     input longint unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Bursts are tracked by sample index: a burst spans first..last mismatch
  // index and closes once GAP_LIMIT clean samples follow the last mismatch.
  longint unsigned m_idx, m_first, m_last;
  bit              m_open, m_ovf;
  int unsigned     m_ts, m_mask, m_err, m_burst;
  int unsigned     m_q[$];
`ifdef CUT_MON_PER_BIT_EN
  int unsigned     m_bit[OUT_W];
`endif

  function automatic int unsigned sat_cnt(input int unsigned x);
    return (x >= 65535) ? x : x + 1;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_first = 0; m_last = 0; m_open = 0; m_ovf = 0;
    m_ts = 0; m_mask = 0; m_err = 0; m_burst = 0;
    m_q.delete();
`ifdef CUT_MON_PER_BIT_EN
    for (int b = 0; b < OUT_W; b++) m_bit[b] = 0;
`endif
  endtask

  task automatic model_step();
    bit              do_close;
    bit              pop;
    int unsigned     d;
    longint unsigned len;
    if (rst) begin
      model_reset();
      return;
    end
    d        = int'(obs ^ gold);
    do_close = 1'b0;
    pop      = (m_q.size() > 0) && evt_ready;
    if (m_open && !enable) begin
      do_close = 1'b1;
    end else if (sample_valid && enable) begin
      if (d != 0) begin
        m_err = sat_cnt(m_err);
`ifdef CUT_MON_PER_BIT_EN
        for (int b = 0; b < OUT_W; b++) if (d[b]) m_bit[b] = sat_cnt(m_bit[b]);
`endif
        if (!m_open) begin
          m_open  = 1'b1;
          m_first = m_idx;
          m_ts    = int'(m_idx % 65536);
          m_mask  = d;
        end else begin
          m_mask = m_mask | d;
        end
        m_last = m_idx;
      end else if (m_open && (m_idx - m_last == GAP_LIMIT)) begin
        do_close = 1'b1;
      end
      m_idx++;
    end
    if (pop) void'(m_q.pop_front());
    if (do_close) begin
      len = m_last - m_first + 1;
      if (len > 255) len = 255;
      if (m_q.size() < DEPTH) m_q.push_back((m_ts << 10) | (int'(len) << 2) | m_mask);
      else m_ovf = 1'b1;
      m_burst = sat_cnt(m_burst);
      m_open  = 1'b0;
    end
  endtask

  // Compare every output against the model once per cycle, on the falling edge.
  always @(negedge clk) begin
    int unsigned h;
    if (chk_en) begin
      h = (m_q.size() > 0) ? m_q[0] : 0;
      cmp("evt_valid", evt_valid, (m_q.size() > 0));
      cmp("evt_start_ts", evt_start_ts, h >> 10);
      cmp("evt_len", evt_len, (h >> 2) & 255);
      cmp("evt_mask", evt_mask, h & 3);
      cmp("err_count", err_count, m_err);
      cmp("burst_count", burst_count, m_burst);
      cmp("overflow", overflow, m_ovf);
      cmp("busy", busy, m_open);
`ifdef CUT_MON_PER_BIT_EN
      for (int b = 0; b < OUT_W; b++)
        cmp("bit_err_count", bit_err_count[b*CNT_W +: CNT_W], m_bit[b]);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge; applies inputs for one rising edge.
  task automatic put(input bit r, input bit v, input bit en,
                     input logic [1:0] o, input logic [1:0] g, input bit rdy);
    rst = r; sample_valid = v; enable = en; obs = o; gold = g; evt_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) put(0, 1, 1, 2'b00, 2'b00, 0);
  endtask

  task automatic mis(input logic [1:0] d);
    put(0, 1, 1, d, 2'b00, 0);
  endtask

  task automatic pop1();
    put(0, 0, 1, 2'b00, 2'b00, 1);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    put(1, 0, 0, 2'b00, 2'b00, 0);
    chk_en = 1'b1;
    put(1, 0, 0, 2'b00, 2'b00, 0);
    cmp("reset evt_valid", evt_valid, 0);
    cmp("reset err_count", err_count, 0);
    cmp("reset busy", busy, 0);

    // Single glitch at ts=5.
    clean(5);
    mis(2'b01);
    clean(3);
    cmp("glitch not yet visible", evt_valid, 0);
    clean(1);
    cmp("glitch evt_valid", evt_valid, 1);
    cmp("glitch start_ts", evt_start_ts, 5);
    cmp("glitch len", evt_len, 1);
    cmp("glitch mask", evt_mask, 1);
    cmp("glitch err_count", err_count, 1);
    cmp("glitch burst_count", burst_count, 1);
    pop1();
    cmp("glitch drained", evt_valid, 0);

    // Merged burst: mismatches at ts=10 and 13.
    mis(2'b10);
    clean(2);
    mis(2'b01);
    clean(4);
    cmp("merged start_ts", evt_start_ts, 10);
    cmp("merged len", evt_len, 4);
    cmp("merged mask", evt_mask, 3);
    cmp("merged err_count", err_count, 3);
    pop1();

    // Split bursts at ts=20 and ts=25.
    clean(2);
    mis(2'b01);
    clean(4);
    mis(2'b10);
    clean(4);
    cmp("split head ts", evt_start_ts, 20);
    cmp("split head len", evt_len, 1);
    pop1();
    cmp("split second ts", evt_start_ts, 25);
    cmp("split second mask", evt_mask, 2);
    pop1();

    // Enable drop at ts=30; ts must stay frozen while disabled.
    mis(2'b11);
    put(0, 1, 0, 2'b11, 2'b00, 0);
    cmp("endrop evt_valid", evt_valid, 1);
    cmp("endrop start_ts", evt_start_ts, 30);
    cmp("endrop len", evt_len, 1);
    cmp("endrop busy", busy, 0);
    put(0, 1, 0, 2'b01, 2'b00, 0);
    cmp("endrop err frozen", err_count, 6);
    mis(2'b01);
    put(0, 0, 0, 2'b00, 2'b00, 0);
    pop1();
    cmp("ts frozen start_ts", evt_start_ts, 31);
    cmp("ts frozen err_count", err_count, 7);
    pop1();

    // Overflow: five bursts with no consumer.
    for (int k = 0; k < 5; k++) begin
      mis(2'b01);
      clean(4);
      cmp("ovf head held", evt_start_ts, 32);
    end
    cmp("ovf overflow", overflow, 1);
    cmp("ovf burst_count", burst_count, 11);
    for (int k = 0; k < 4; k++) begin
      cmp("ovf drain order", evt_start_ts, 32 + 5 * k);
      pop1();
    end
    cmp("ovf drained", evt_valid, 0);

    // Length saturation.
    for (int k = 0; k < 300; k++) mis(2'b10);
    clean(4);
    cmp("sat start_ts", evt_start_ts, 57);
    cmp("sat len", evt_len, 255);
    pop1();

    // Reset in the middle of a burst.
    mis(2'b01);
    put(1, 0, 0, 2'b00, 2'b00, 0);
    cmp("rst evt_valid", evt_valid, 0);
    cmp("rst err_count", err_count, 0);
    cmp("rst burst_count", burst_count, 0);
    cmp("rst overflow", overflow, 0);
    cmp("rst busy", busy, 0);
`ifdef CUT_MON_PER_BIT_EN
    cmp("rst bit_err_count", bit_err_count, 0);
`endif
    mis(2'b10);
    clean(4);
    cmp("post-rst start_ts", evt_start_ts, 0);
    cmp("post-rst mask", evt_mask, 2);
    pop1();

    // Randomized traffic.
    for (int c = 0; c < 5000; c++) begin
      bit          r, v, en, rdy;
      logic [1:0]  o, g;
      r   = ($urandom_range(0, 1499) == 0);
      v   = ($urandom_range(0, 9) < 8);
      en  = ($urandom_range(0, 39) != 0);
      rdy = ((c / 200) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      o   = 2'($urandom);
      g   = ($urandom_range(0, 5) == 0) ? 2'($urandom) : o;
      put(r, v, en, o, g, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cut_response_monitor.md
Name: cut_response_monitor

Overview:
- Reader-side counterpart to the gate-level circuits under test (CUT) in the intermittent-fault flow.
- Samples the CUT output vector every valid cycle and compares it against the golden (fault-free) output.
- Groups mismatches into intermittent-fault bursts and emits one event record per burst over a valid/ready stream.
- The stream feeds the trace collector that builds the LSTM detection dataset.

Parameters:
- OUT_W, 2, width of the CUT output vector being compared.
- TS_W, 16, sample timestamp width; wraps modulo 2^TS_W.
- LEN_W, 8, burst length field width; saturates.
- CNT_W, 16, total mismatch and burst counter width; saturates.
- GAP_LIMIT, 4, consecutive clean samples that close a burst; legal range 1..255.
- FIFO_DEPTH, 4, event FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  monitor active; deassertion flushes any open burst.
- sample_valid  in  1  obs/gold valid this cycle.
- obs  in  OUT_W  observed CUT outputs.
- gold  in  OUT_W  golden CUT outputs.
- evt_valid  out  1  event record available.
- evt_ready  in  1  consumer accepts the record.
- evt_start_ts  out  TS_W  timestamp of the first mismatching sample.
- evt_len  out  LEN_W  samples from first to last mismatch, inclusive.
- evt_mask  out  OUT_W  OR of (obs XOR gold) over the burst.
- err_count  out  CNT_W  mismatching samples seen.
- burst_count  out  CNT_W  bursts closed, including dropped ones.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: every output is 0. FIFO empty, state IDLE, timestamp 0.
- Timestamp ts:
  - Increments by 1 on each cycle where sample_valid && enable.
  - The sample in that cycle carries the pre-increment value.
  - Wraps to 0 after 2^TS_W-1.
- Mismatch condition: mis = sample_valid && enable && (obs != gold).
  - err_count increments on every mis and saturates at all-ones.
- States:
  - IDLE:
    - On mis: capture start_ts=ts, len=1, mask=obs^gold, then go to BURST.
  - BURST:
    - mis: len=len+1+gap (gap is 0 here), mask|=obs^gold.
    - Clean valid sample: gap=1. If GAP_LIMIT==1, close; otherwise go to GAP.
  - GAP:
    - mis: len=len+gap+1, mask|=obs^gold, gap=0, go to BURST.
    - Clean valid sample: gap++. When gap reaches GAP_LIMIT, close.
- Cycles without sample_valid do not advance gap, len or ts.
- len saturates at 2^LEN_W-1.
- Close: push {start_ts,len,mask}, increment burst_count (saturating), go to IDLE.
  - The closing sample at cycle t makes the record visible with evt_valid=1 in cycle t+1 when the FIFO was empty.
  - The closing sample is never itself a mismatch, so IDLE does not re-arm in the same cycle.
- enable falling edge while in BURST or GAP: close immediately, using the current len and mask. No sample is processed that cycle.
- FIFO behaviour:
  - A record transfers when evt_valid && evt_ready.
  - evt_* outputs hold stable while evt_valid=1 and evt_ready=0.
  - Outputs show the head entry (first-word fall-through from registers).
- FIFO full on close:
  - If a pop happens in the same cycle, the push is accepted.
  - Otherwise the record is dropped, overflow is set, and burst_count still increments.
- overflow clears only on rst.
- rst mid-burst: the open burst is discarded and no record is emitted.

Optional Feature:
- Macro CUT_MON_PER_BIT_EN.
- Defined:
  - Adds output bit_err_count[OUT_W*CNT_W].
  - One saturating counter per output bit, incremented when that bit mismatches on a valid enabled sample. Reset to 0.
- Undefined: the port and counters are absent. All other behaviour is identical.

Decomposition:
- Package cut_mon_pkg:
  - state enum {IDLE,BURST,GAP}.
  - Event record struct {start_ts,len,mask}, parameterised via package localparams matching the defaults.
  - Saturating-increment function.
- One sub-module, cut_mon_fifo:
  - Synchronous FIFO with valid/ready on both sides and registered outputs.
  - Exposes full, empty and push_accepted.

Test Plan:
- Single glitch: obs^gold=01 at ts=5, then 4 clean samples -> one record {5,1,01}; err_count=1, burst_count=1; evt_valid in the cycle after the 4th clean sample.
- Merged burst: mismatches (10) at ts=10 and (01) at ts=13, clean at 11,12, then 4 clean -> {10,4,11}; err_count=2.
- Split bursts: mismatch at ts=20, 4 clean, mismatch at ts=25 -> two records {20,1,..} and {25,1,..}.
- Backpressure/overflow: evt_ready=0, close 5 bursts -> 4 records held with stable outputs, overflow=1, burst_count=5; on draining, records come out in order.
- Enable drop: mismatch at ts=30, enable=0 on the next cycle -> record {30,1,..} emitted, state IDLE, busy=0; ts frozen while enable=0.
- Reset mid-burst: mismatch, then rst -> no record, all outputs 0; with CUT_MON_PER_BIT_EN, per-bit counts are 0.
